// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared constants for the push-button conditioner and the
//               quick/slow mode FSM (default timings, channel encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;
  localparam int unsigned BTN_STABLE_DEFAULT = 1_000_000;
  localparam int unsigned BTN_REPEAT_DEFAULT = 50_000_000;

  // Channel encoding, also used by the mode FSM as its speed select
  localparam logic        BTN_QUICK = 1'b0;
  localparam logic        BTN_SLOW  = 1'b1;
  localparam int unsigned BTN_NUM   = 2;

  typedef logic [BTN_NUM-1:0] btn_vec_t;
endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================================
// Module      : btn_channel
// Description : One button: 2-flop synchroniser, stable-time debounce and
//               rising-edge pulse. Optional auto-repeat with BTN_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = BTN_STABLE_DEFAULT,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_DEFAULT,
  parameter int unsigned REP_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Any sample equal to the debounced level restarts the stable-time count
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == STABLE_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_hit;

  assign rep_hit = db_q && (rep_q == REP_LAST);

  always_comb begin
    rep_d = rep_q + REP_W'(1);
    if (!db_q || rep_hit) begin
      rep_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  // Gating with db_d suppresses a repeat landing on the release edge
  assign pulse_d = db_d && (!db_q || rep_hit);
`else
  logic rep_unused;
  assign rep_unused = ^{REPEAT_CYCLES, REP_W};
  assign pulse_d    = db_d && !db_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw_i;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module      : btn_conditioner
// Description : Conditions the raw quick/slow buttons into one-cycle pulses
//               for the mode FSM. Auto-repeat enabled by BTN_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = BTN_STABLE_DEFAULT,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_DEFAULT,
  parameter int unsigned REP_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_quick_raw,
  input  logic btn_slow_raw,
  output logic quick_processed,
  output logic slow_processed
);

  btn_vec_t raw_vec;
  btn_vec_t pulse_vec;

  assign raw_vec[BTN_QUICK] = btn_quick_raw;
  assign raw_vec[BTN_SLOW]  = btn_slow_raw;

  // Channels are independent; simultaneous pulses are resolved downstream
  for (genvar g = 0; g < BTN_NUM; g++) begin : g_ch
    btn_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REP_W         (REP_W)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .btn_raw_i (raw_vec[g]),
      .pulse_o   (pulse_vec[g])
    );
  end

  assign quick_processed = pulse_vec[BTN_QUICK];
  assign slow_processed  = pulse_vec[BTN_SLOW];

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Directed bench for btn_conditioner, STABLE=4, REPEAT=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

  localparam int unsigned STABLE = 4;
  localparam int unsigned REPEAT = 8;

`ifdef BTN_REPEAT_EN
  localparam int EXP_CLEAN_N  = 4;
  localparam int EXP_CLEAN_L  = 30;
  localparam int EXP_BOUNCE_N = 4;
  localparam int EXP_BOUNCE_L = 34;
`else
  localparam int EXP_CLEAN_N  = 1;
  localparam int EXP_CLEAN_L  = 6;
  localparam int EXP_BOUNCE_N = 1;
  localparam int EXP_BOUNCE_L = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_quick_raw = 1'b0;
  logic btn_slow_raw  = 1'b0;
  logic quick_processed;
  logic slow_processed;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(
    .STABLE_CYCLES (STABLE),
    .CNT_W         (4),
    .REPEAT_CYCLES (REPEAT),
    .REP_W         (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_quick_raw   (btn_quick_raw),
    .btn_slow_raw    (btn_slow_raw),
    .quick_processed (quick_processed),
    .slow_processed  (slow_processed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of each pattern is driven before edge i+1; outputs sampled after it.
  // Reports pulse count, first and last edge index (0 when none).
  task automatic run_vec(input int n, input logic [63:0] qp, input logic [63:0] sp,
                         output int qn, output int qf, output int ql,
                         output int sn, output int sf, output int sl);
    qn = 0; qf = 0; ql = 0;
    sn = 0; sf = 0; sl = 0;
    for (int i = 0; i < n; i++) begin
      btn_quick_raw = qp[i];
      btn_slow_raw  = sp[i];
      tick();
      if (quick_processed) begin
        qn++;
        if (qf == 0) qf = i + 1;
        ql = i + 1;
      end
      if (slow_processed) begin
        sn++;
        if (sf == 0) sf = i + 1;
        sl = i + 1;
      end
    end
  endtask

  initial begin
    int qn, qf, ql, sn, sf, sl;

    // Reset state
    rst = 1'b0;
    btn_quick_raw = 1'b1;
    btn_slow_raw  = 1'b1;
    repeat (3) tick();
    check("rst_quick", int'(quick_processed), 0);
    check("rst_slow",  int'(slow_processed), 0);
    btn_quick_raw = 1'b0;
    btn_slow_raw  = 1'b0;
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_quick", int'(quick_processed), 0);
    check("post_rst_slow",  int'(slow_processed), 0);

    // Clean press held 30 cycles, then release
    run_vec(48, 64'h3FFF_FFFF, 64'h0, qn, qf, ql, sn, sf, sl);
    check("clean_q_count", qn, EXP_CLEAN_N);
    check("clean_q_first", qf, 6);
    check("clean_q_last",  ql, EXP_CLEAN_L);
    check("clean_s_count", sn, 0);

    // Glitch of 3 cycles is ignored
    run_vec(20, 64'h7, 64'h0, qn, qf, ql, sn, sf, sl);
    check("glitch3_q_count", qn, 0);

    // 4 cycles is just long enough
    run_vec(20, 64'hF, 64'h0, qn, qf, ql, sn, sf, sl);
    check("press4_q_count", qn, 1);
    check("press4_q_first", qf, 6);

    // Bounce 1,0,1,0 then hold on slow
    run_vec(48, 64'h0, 64'h3FFF_FFF5, qn, qf, ql, sn, sf, sl);
    check("bounce_s_count", sn, EXP_BOUNCE_N);
    check("bounce_s_first", sf, 10);
    check("bounce_s_last",  sl, EXP_BOUNCE_L);
    check("bounce_q_count", qn, 0);

    // Simultaneous press
    run_vec(24, 64'h3F, 64'h3F, qn, qf, ql, sn, sf, sl);
    check("simul_q_first", qf, 6);
    check("simul_s_first", sf, 6);
    check("simul_q_count", qn, 1);
    check("simul_s_count", sn, 1);

    // Reset mid-count with quick held
    btn_quick_raw = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("midrst_q_imm", int'(quick_processed), 0);
    tick();
    check("midrst_q_c1", int'(quick_processed), 0);
    tick();
    check("midrst_q_c2", int'(quick_processed), 0);
    rst = 1'b1;
    run_vec(24, 64'h3F, 64'h0, qn, qf, ql, sn, sf, sl);
    check("midrst_q_count", qn, 1);
    check("midrst_q_first", qf, 6);
    check("midrst_s_count", sn, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
